// File: rtl/set_bit_walker.sv
// Captures a word and walks its set bits one per step strobe, LSB- or MSB-first.
// Optional macro SET_BIT_WALKER_WRAP_EN: a step in DONE restarts the walk of the captured word.
module set_bit_walker #(
    parameter int WIDTH     = 10,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       load_i,
    input  logic                       step_i,
    output logic [WIDTH-1:0]           onehot_o,
    output logic [$clog2(WIDTH)-1:0]   index_o,
    output logic [$clog2(WIDTH+1)-1:0] count_o,
    output logic                       valid_o,
    output logic                       done_o
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH+1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WALK = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] orig_q, orig_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] onehot_q, pick_d;
    logic [IDX_W-1:0] index_q, idx_d;
    logic [CNT_W-1:0] count_q, cnt_d;
    logic             valid_q, done_q;

    // Load has priority over step; in IDLE/DONE rem is always zero.
    always_comb begin
        state_d = state_q;
        orig_d  = orig_q;
        rem_d   = rem_q;
        if (load_i) begin
            orig_d  = data_i;
            rem_d   = data_i;
            state_d = (data_i != '0) ? S_WALK : S_DONE;
        end else if (step_i) begin
            case (state_q)
                S_WALK: begin
                    rem_d = rem_q & ~onehot_q;
                    if (rem_d == '0) state_d = S_DONE;
                end
`ifdef SET_BIT_WALKER_WRAP_EN
                S_DONE: begin
                    if (orig_q != '0) begin
                        rem_d   = orig_q;
                        state_d = S_WALK;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Outputs are derived from the next remainder so they land in the same edge.
    always_comb begin
        pick_d = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (rem_d[i]) begin
                    pick_d    = '0;
                    pick_d[i] = 1'b1;
                end
            end
        end else begin
            pick_d = rem_d & (~rem_d + WIDTH'(1));
        end
    end

    always_comb begin
        idx_d = '0;
        cnt_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pick_d[i]) idx_d = IDX_W'(i);
            cnt_d = cnt_d + CNT_W'(rem_d[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q  <= S_IDLE;
            orig_q   <= '0;
            rem_q    <= '0;
            onehot_q <= '0;
            index_q  <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            orig_q   <= orig_d;
            rem_q    <= rem_d;
            onehot_q <= pick_d;
            index_q  <= idx_d;
            count_q  <= cnt_d;
            valid_q  <= (state_d == S_WALK);
            done_q   <= (state_d == S_DONE);
        end
    end

    assign onehot_o = onehot_q;
    assign index_o  = index_q;
    assign count_o  = count_q;
    assign valid_o  = valid_q;
    assign done_o   = done_q;

endmodule
